// File: rtl/cdb_pkg.sv
// Shared constants for the common data bus arbiter: arbitration mode encodings
// and the branch-prediction-buffer index width.
package cdb_pkg;

  typedef enum int {
    ARB_FIXED  = 0,
    ARB_RR     = 1,
    ARB_OLDEST = 2
  } arb_mode_e;

  localparam int BPB_W = 3;

endpackage

// File: rtl/cdb_arb_sel.sv
// Combinational winner select: fixed priority, round-robin from a pointer, or
// oldest-first by ROB depth. Produces a one-hot grant and the winner's index.
module cdb_arb_sel
  import cdb_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int TAG_W    = 5,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]       i_req,
  input  logic [NUM_SRC*TAG_W-1:0] i_depth,
  input  logic [SRC_W-1:0]         i_rr_ptr,
  output logic [NUM_SRC-1:0]       o_grant,
  output logic [SRC_W-1:0]         o_idx,
  output logic                     o_any
);

  logic [TAG_W-1:0] w_best_depth;
  logic             w_unused;

  // Depth and pointer are only consulted by some modes.
  assign w_unused = ^{i_depth, i_rr_ptr};

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_grant      = '0;
    o_idx        = '0;
    o_any        = 1'b0;
    w_best_depth = '1;
    if (ARB_MODE == int'(ARB_RR)) begin
      // Scan offsets from the far end so the smallest offset from the pointer wins.
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          if (i_req[j] && (j == (int'(i_rr_ptr) + k) % NUM_SRC)) begin
            o_grant    = '0;
            o_grant[j] = 1'b1;
            o_idx      = SRC_W'(j);
            o_any      = 1'b1;
          end
        end
      end
    end else if (ARB_MODE == int'(ARB_OLDEST)) begin
      // Strict less-than keeps the lowest index on equal depths.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i_req[i] && (!o_any || (i_depth[i*TAG_W +: TAG_W] < w_best_depth))) begin
          w_best_depth = i_depth[i*TAG_W +: TAG_W];
          o_grant      = '0;
          o_grant[i]   = 1'b1;
          o_idx        = SRC_W'(i);
          o_any        = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
          o_idx      = SRC_W'(i);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter_n.sv
// Common data bus: merges NUM_SRC result channels onto one registered CDB,
// squashing results younger than a broadcast mispredict.
module cdb_arbiter_n
  import cdb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DATA_W       = 32,
  parameter int PHY_W        = 6,
  parameter int TAG_W        = 5,
  parameter int AUX_W        = 32,
  parameter int DEPTH_COPIES = 9,
  parameter int ARB_MODE     = ARB_FIXED,
  localparam int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                        Clk,
  input  logic                        Resetb,
  input  logic [TAG_W:0]              Rob_TopPtr,
  input  logic                        Rob_Commit,
  input  logic [NUM_SRC-1:0]          Src_Valid,
  output logic [NUM_SRC-1:0]          Src_Ready,
  input  logic [NUM_SRC*DATA_W-1:0]   Src_Data,
  input  logic [NUM_SRC*PHY_W-1:0]    Src_PhyAddr,
  input  logic [NUM_SRC*TAG_W-1:0]    Src_RobTag,
  input  logic [NUM_SRC-1:0]          Src_RdWrite,
  input  logic [NUM_SRC-1:0]          Src_Branch,
  input  logic [NUM_SRC-1:0]          Src_BranchOutcome,
  input  logic [NUM_SRC-1:0]          Src_BranchPredict,
  input  logic [NUM_SRC-1:0]          Src_JrFlush,
  input  logic [NUM_SRC*DATA_W-1:0]   Src_BranchAddr,
  input  logic [NUM_SRC*BPB_W-1:0]    Src_BranchUpdtAddr,
  input  logic [NUM_SRC*AUX_W-1:0]    Src_Aux,
  output logic                        Cdb_Valid,
  output logic                        Cdb_PhyRegWrite,
  output logic                        Cdb_Branch,
  output logic                        Cdb_BranchOutcome,
  output logic                        Cdb_Flush,
  output logic [DATA_W-1:0]           Cdb_Data,
  output logic [DATA_W-1:0]           Cdb_BranchAddr,
  output logic [PHY_W-1:0]            Cdb_RdPhyAddr,
  output logic [TAG_W-1:0]            Cdb_RobTag,
  output logic [BPB_W-1:0]            Cdb_BranchUpdtAddr,
  output logic [AUX_W-1:0]            Cdb_Aux,
  output logic [SRC_W-1:0]            Cdb_SrcId,
  output logic [DEPTH_COPIES*TAG_W-1:0] Cdb_RobDepth
);

  logic [NUM_SRC*TAG_W-1:0] w_src_depth;
  logic [NUM_SRC-1:0]       w_squash;
  logic [NUM_SRC-1:0]       w_req;
  logic [NUM_SRC-1:0]       w_grant;
  logic [SRC_W-1:0]         w_win;
  logic                     w_any;
  logic [SRC_W-1:0]         w_rr_next;
  logic [TAG_W-1:0]         w_head_next;
  logic [TAG_W-1:0]         w_win_depth;
  logic                     w_win_flush;
  logic                     w_unused;

  logic [DATA_W-1:0] w_sel_data, w_sel_baddr;
  logic [PHY_W-1:0]  w_sel_phy;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [BPB_W-1:0]  w_sel_bupdt;
  logic [AUX_W-1:0]  w_sel_aux;
  logic              w_sel_rdwr, w_sel_br, w_sel_out, w_sel_pred, w_sel_jr;

  logic              r_valid, r_rd_write, r_branch, r_outcome, r_flush;
  logic [DATA_W-1:0] r_data, r_baddr;
  logic [PHY_W-1:0]  r_phy;
  logic [TAG_W-1:0]  r_tag;
  logic [BPB_W-1:0]  r_bupdt;
  logic [AUX_W-1:0]  r_aux;
  logic [SRC_W-1:0]  r_src_id;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [TAG_W-1:0]  r_rob_depth [DEPTH_COPIES];

  // Only the low TAG_W bits of the head pointer index the ROB.
  assign w_unused = Rob_TopPtr[TAG_W];

  always_comb begin
    w_src_depth = '0;
    w_squash    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src_depth[i*TAG_W +: TAG_W] = Src_RobTag[i*TAG_W +: TAG_W] - Rob_TopPtr[TAG_W-1:0];
      w_squash[i] = r_flush && Src_Valid[i] && (w_src_depth[i*TAG_W +: TAG_W] > r_rob_depth[0]);
    end
  end

  assign w_req = Src_Valid & ~w_squash;

  cdb_arb_sel #(
    .NUM_SRC  (NUM_SRC),
    .TAG_W    (TAG_W),
    .ARB_MODE (ARB_MODE)
  ) u_sel (
    .i_req    (w_req),
    .i_depth  (w_src_depth),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_win),
    .o_any    (w_any)
  );

  // Nothing is accepted while reset holds the CDB register clear.
  assign Src_Ready = (w_squash | w_grant) & {NUM_SRC{Resetb}};

  always_comb begin
    w_sel_data  = '0;
    w_sel_baddr = '0;
    w_sel_phy   = '0;
    w_sel_tag   = '0;
    w_sel_bupdt = '0;
    w_sel_aux   = '0;
    w_sel_rdwr  = 1'b0;
    w_sel_br    = 1'b0;
    w_sel_out   = 1'b0;
    w_sel_pred  = 1'b0;
    w_sel_jr    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_data  = Src_Data[i*DATA_W +: DATA_W];
        w_sel_baddr = Src_BranchAddr[i*DATA_W +: DATA_W];
        w_sel_phy   = Src_PhyAddr[i*PHY_W +: PHY_W];
        w_sel_tag   = Src_RobTag[i*TAG_W +: TAG_W];
        w_sel_bupdt = Src_BranchUpdtAddr[i*BPB_W +: BPB_W];
        w_sel_aux   = Src_Aux[i*AUX_W +: AUX_W];
        w_sel_rdwr  = Src_RdWrite[i];
        w_sel_br    = Src_Branch[i];
        w_sel_out   = Src_BranchOutcome[i];
        w_sel_pred  = Src_BranchPredict[i];
        w_sel_jr    = Src_JrFlush[i];
      end
    end
  end

  assign w_win_flush = w_sel_jr | (w_sel_br & (w_sel_out != w_sel_pred));
  assign w_rr_next   = (w_win == SRC_W'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
  // Depth is taken against the head of the broadcast cycle, after this cycle's commit.
  assign w_head_next = Rob_TopPtr[TAG_W-1:0] + {{(TAG_W-1){1'b0}}, Rob_Commit};
  assign w_win_depth = w_sel_tag - w_head_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      r_valid    <= 1'b0;
      r_rd_write <= 1'b0;
      r_branch   <= 1'b0;
      r_outcome  <= 1'b0;
      r_flush    <= 1'b0;
      r_data     <= '0;
      r_baddr    <= '0;
      r_phy      <= '0;
      r_tag      <= '0;
      r_bupdt    <= '0;
      r_aux      <= '0;
      r_src_id   <= '0;
      r_rr_ptr   <= '0;
      // NOTE: the depth copies feed the squash compare, so the whole array is reset.
      for (int c = 0; c < DEPTH_COPIES; c++) r_rob_depth[c] <= '0;
    end else begin
      r_valid    <= w_any;
      r_rd_write <= w_any & w_sel_rdwr;
      r_branch   <= w_any & w_sel_br;
      r_flush    <= w_any & w_win_flush;
      if (w_any) begin
        r_outcome <= w_sel_out;
        r_data    <= w_sel_data;
        r_baddr   <= w_sel_baddr;
        r_phy     <= w_sel_phy;
        r_tag     <= w_sel_tag;
        r_bupdt   <= w_sel_bupdt;
        r_aux     <= w_sel_aux;
        r_src_id  <= w_win;
        r_rr_ptr  <= w_rr_next;
        for (int c = 0; c < DEPTH_COPIES; c++) r_rob_depth[c] <= w_win_depth;
      end
    end
  end

  assign Cdb_Valid          = r_valid;
  assign Cdb_PhyRegWrite    = r_rd_write;
  assign Cdb_Branch         = r_branch;
  assign Cdb_BranchOutcome  = r_outcome;
  assign Cdb_Flush          = r_flush;
  assign Cdb_Data           = r_data;
  assign Cdb_BranchAddr     = r_baddr;
  assign Cdb_RdPhyAddr      = r_phy;
  assign Cdb_RobTag         = r_tag;
  assign Cdb_BranchUpdtAddr = r_bupdt;
  assign Cdb_Aux            = r_aux;
  assign Cdb_SrcId          = r_src_id;

  for (genvar g = 0; g < DEPTH_COPIES; g++) begin : g_depth
    assign Cdb_RobDepth[g*TAG_W +: TAG_W] = r_rob_depth[g];
  end

endmodule

// File: tb/tb_cdb_arbiter_n.sv
// Directed bench for cdb_arbiter_n: one instance per arbitration mode, all
// driven by the same source stimulus, with hand-computed expectations.
module tb_cdb_arbiter_n;

  logic         Clk = 1'b0;
  logic         Resetb;
  logic [5:0]   Rob_TopPtr;
  logic         Rob_Commit;
  logic [3:0]   Src_Valid;
  logic [127:0] Src_Data;
  logic [23:0]  Src_PhyAddr;
  logic [19:0]  Src_RobTag;
  logic [3:0]   Src_RdWrite, Src_Branch, Src_BranchOutcome, Src_BranchPredict, Src_JrFlush;
  logic [127:0] Src_BranchAddr;
  logic [11:0]  Src_BranchUpdtAddr;
  logic [127:0] Src_Aux;

  logic [3:0]  fx_ready, rr_ready, od_ready;
  logic        fx_valid, fx_wr, fx_br, fx_out, fx_flush;
  logic        rr_valid, rr_wr, rr_br, rr_out, rr_flush;
  logic        od_valid, od_wr, od_br, od_out, od_flush;
  logic [31:0] fx_data, fx_baddr, fx_aux, rr_data, rr_baddr, rr_aux, od_data, od_baddr, od_aux;
  logic [5:0]  fx_phy, rr_phy, od_phy;
  logic [4:0]  fx_tag, rr_tag, od_tag;
  logic [2:0]  fx_bupdt, rr_bupdt, od_bupdt;
  logic [1:0]  fx_id, rr_id, od_id;
  logic [44:0] fx_depth, rr_depth, od_depth;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  cdb_arbiter_n #(.ARB_MODE(0)) dut_fx (
    .Clk(Clk), .Resetb(Resetb), .Rob_TopPtr(Rob_TopPtr), .Rob_Commit(Rob_Commit),
    .Src_Valid(Src_Valid), .Src_Ready(fx_ready), .Src_Data(Src_Data),
    .Src_PhyAddr(Src_PhyAddr), .Src_RobTag(Src_RobTag), .Src_RdWrite(Src_RdWrite),
    .Src_Branch(Src_Branch), .Src_BranchOutcome(Src_BranchOutcome),
    .Src_BranchPredict(Src_BranchPredict), .Src_JrFlush(Src_JrFlush),
    .Src_BranchAddr(Src_BranchAddr), .Src_BranchUpdtAddr(Src_BranchUpdtAddr), .Src_Aux(Src_Aux),
    .Cdb_Valid(fx_valid), .Cdb_PhyRegWrite(fx_wr), .Cdb_Branch(fx_br),
    .Cdb_BranchOutcome(fx_out), .Cdb_Flush(fx_flush), .Cdb_Data(fx_data),
    .Cdb_BranchAddr(fx_baddr), .Cdb_RdPhyAddr(fx_phy), .Cdb_RobTag(fx_tag),
    .Cdb_BranchUpdtAddr(fx_bupdt), .Cdb_Aux(fx_aux), .Cdb_SrcId(fx_id), .Cdb_RobDepth(fx_depth)
  );

  cdb_arbiter_n #(.ARB_MODE(1)) dut_rr (
    .Clk(Clk), .Resetb(Resetb), .Rob_TopPtr(Rob_TopPtr), .Rob_Commit(Rob_Commit),
    .Src_Valid(Src_Valid), .Src_Ready(rr_ready), .Src_Data(Src_Data),
    .Src_PhyAddr(Src_PhyAddr), .Src_RobTag(Src_RobTag), .Src_RdWrite(Src_RdWrite),
    .Src_Branch(Src_Branch), .Src_BranchOutcome(Src_BranchOutcome),
    .Src_BranchPredict(Src_BranchPredict), .Src_JrFlush(Src_JrFlush),
    .Src_BranchAddr(Src_BranchAddr), .Src_BranchUpdtAddr(Src_BranchUpdtAddr), .Src_Aux(Src_Aux),
    .Cdb_Valid(rr_valid), .Cdb_PhyRegWrite(rr_wr), .Cdb_Branch(rr_br),
    .Cdb_BranchOutcome(rr_out), .Cdb_Flush(rr_flush), .Cdb_Data(rr_data),
    .Cdb_BranchAddr(rr_baddr), .Cdb_RdPhyAddr(rr_phy), .Cdb_RobTag(rr_tag),
    .Cdb_BranchUpdtAddr(rr_bupdt), .Cdb_Aux(rr_aux), .Cdb_SrcId(rr_id), .Cdb_RobDepth(rr_depth)
  );

  cdb_arbiter_n #(.ARB_MODE(2)) dut_od (
    .Clk(Clk), .Resetb(Resetb), .Rob_TopPtr(Rob_TopPtr), .Rob_Commit(Rob_Commit),
    .Src_Valid(Src_Valid), .Src_Ready(od_ready), .Src_Data(Src_Data),
    .Src_PhyAddr(Src_PhyAddr), .Src_RobTag(Src_RobTag), .Src_RdWrite(Src_RdWrite),
    .Src_Branch(Src_Branch), .Src_BranchOutcome(Src_BranchOutcome),
    .Src_BranchPredict(Src_BranchPredict), .Src_JrFlush(Src_JrFlush),
    .Src_BranchAddr(Src_BranchAddr), .Src_BranchUpdtAddr(Src_BranchUpdtAddr), .Src_Aux(Src_Aux),
    .Cdb_Valid(od_valid), .Cdb_PhyRegWrite(od_wr), .Cdb_Branch(od_br),
    .Cdb_BranchOutcome(od_out), .Cdb_Flush(od_flush), .Cdb_Data(od_data),
    .Cdb_BranchAddr(od_baddr), .Cdb_RdPhyAddr(od_phy), .Cdb_RobTag(od_tag),
    .Cdb_BranchUpdtAddr(od_bupdt), .Cdb_Aux(od_aux), .Cdb_SrcId(od_id), .Cdb_RobDepth(od_depth)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rob_TopPtr = '0;          Rob_Commit = 1'b0;
    Src_Valid = '0;           Src_Data = '0;          Src_PhyAddr = '0;
    Src_RobTag = '0;          Src_RdWrite = '0;       Src_Branch = '0;
    Src_BranchOutcome = '0;   Src_BranchPredict = '0; Src_JrFlush = '0;
    Src_BranchAddr = '0;      Src_BranchUpdtAddr = '0; Src_Aux = '0;
  endtask

  // Reset all instances; returns at a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    Resetb = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Resetb = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic [4:0] tag, input logic [31:0] data);
    Src_RobTag[ch*5 +: 5]          = tag;
    Src_Data[ch*32 +: 32]          = data;
    Src_PhyAddr[ch*6 +: 6]         = data[5:0];
    Src_BranchAddr[ch*32 +: 32]    = ~data;
    Src_BranchUpdtAddr[ch*3 +: 3]  = data[2:0];
    Src_Aux[ch*32 +: 32]           = data ^ 32'h5A5A_0000;
  endtask

  initial begin
    // Reset state, with all channels presenting: nothing may be accepted.
    clear_inputs();
    Resetb = 1'b0;
    Src_Valid = 4'b1111;
    #3;
    check("reset_ready", 64'(fx_ready), 64'h0);
    check("reset_valid", 64'(fx_valid), 64'h0);
    check("reset_depth_od", 64'(od_depth), 64'h0);
    check("reset_srcid_rr", 64'(rr_id), 64'h0);

    // Fixed priority collision on channels 1 and 3.
    do_reset();
    set_ch(1, 5'd3, 32'h1111_0011);
    set_ch(3, 5'd4, 32'h3333_0033);
    Src_Valid = 4'b1010;
    #1 check("fx_collide_ready", 64'(fx_ready), 64'b0010);
    step();
    check("fx_collide_srcid", 64'(fx_id), 64'd1);
    check("fx_collide_valid", 64'(fx_valid), 64'd1);
    check("fx_collide_data", 64'(fx_data), 64'h1111_0011);
    Src_Valid = 4'b1000;
    #1 check("fx_second_ready", 64'(fx_ready), 64'b1000);
    step();
    check("fx_second_srcid", 64'(fx_id), 64'd3);
    check("fx_second_aux", 64'(fx_aux), 64'h6969_0033);
    check("fx_second_baddr", 64'(fx_baddr), 64'hCCCC_FFCC);
    Src_Valid = 4'b0000;
    step();
    check("fx_idle_valid", 64'(fx_valid), 64'd0);
    check("fx_idle_data_held", 64'(fx_data), 64'h3333_0033);

    // Round-robin with every channel always valid.
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 5'(c + 1), 32'hA000_0000 + 32'(c));
    Src_Valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr_ready_%0d", k), 64'(rr_ready), 64'(4'b0001 << (k % 4)));
      step();
      check($sformatf("rr_srcid_%0d", k), 64'(rr_id), 64'(k % 4));
    end

    // Oldest-first with wrap-around: head 30, ch0 tag 1 (depth 3), ch2 tag 31 (depth 1).
    do_reset();
    Rob_TopPtr = 6'd30;
    set_ch(0, 5'd1, 32'h0000_00A0);
    set_ch(2, 5'd31, 32'h0000_00C2);
    Src_Valid  = 4'b0101;
    Rob_Commit = 1'b1;
    #1 check("od_oldest_ready", 64'(od_ready), 64'b0100);
    check("fx_lowest_ready", 64'(fx_ready), 64'b0001);
    step();
    check("od_srcid", 64'(od_id), 64'd2);
    check("od_depth_commit", 64'(od_depth), 64'({9{5'd0}}));
    check("od_robtag", 64'(od_tag), 64'd31);
    Rob_TopPtr = 6'd31;
    Rob_Commit = 1'b0;
    Src_Valid  = 4'b0001;
    #1 check("od_ch0_ready", 64'(od_ready), 64'b0001);
    step();
    check("od_depth_wrap", 64'(od_depth), 64'({9{5'd2}}));
    check("od_bupdt", 64'(od_bupdt), 64'd0);

    // Mispredicted ALU branch at depth 2, then younger ch1 (depth 5) is squashed.
    do_reset();
    set_ch(0, 5'd2, 32'h0000_B000);
    Src_Branch[0] = 1'b1;
    Src_BranchPredict[0] = 1'b1;
    Src_BranchOutcome[0] = 1'b0;
    Src_Valid = 4'b0001;
    step();
    check("mp_flush", 64'(fx_flush), 64'd1);
    check("mp_branch", 64'(fx_br), 64'd1);
    check("mp_depth0", 64'(fx_depth[4:0]), 64'd2);
    check("mp_bupdt", 64'(fx_bupdt), 64'd0);
    clear_inputs();
    set_ch(1, 5'd5, 32'hDEAD_0001);
    set_ch(2, 5'd1, 32'h0000_0C22);
    Src_Valid = 4'b0110;
    #1 check("mp_squash_ready", 64'(fx_ready), 64'b0110);
    step();
    check("mp_after_srcid", 64'(fx_id), 64'd2);
    check("mp_after_flush", 64'(fx_flush), 64'd0);
    Src_Valid = 4'b0000;
    step();
    check("mp_no_ch1", 64'(fx_data), 64'h0000_0C22);

    // JR flush from the ALU.
    clear_inputs();
    set_ch(0, 5'd3, 32'h0000_0777);
    Src_JrFlush[0] = 1'b1;
    Src_Valid = 4'b0001;
    step();
    check("jr_flush", 64'(fx_flush), 64'd1);
    check("jr_branch", 64'(fx_br), 64'd0);

    // Reset asserted with results pending.
    clear_inputs();
    step();
    for (int c = 0; c < 4; c++) set_ch(c, 5'(c + 4), 32'hF000_0000 + 32'(c));
    Src_RdWrite = 4'b1111;
    Src_Valid   = 4'b1111;
    step();
    check("rst_pre_wr", 64'(fx_wr), 64'd1);
    #1 Resetb = 1'b0;
    #1 check("rst_async_valid", 64'(fx_valid), 64'd0);
    check("rst_async_data", 64'(fx_data), 64'd0);
    check("rst_async_ready", 64'(fx_ready), 64'd0);
    @(negedge Clk);
    Resetb = 1'b1;
    #1 check("rst_post_ready", 64'(fx_ready), 64'b0001);
    step();
    check("rst_post_valid", 64'(fx_valid), 64'd1);
    check("rst_post_data", 64'(fx_data), 64'hF000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
